// File: rtl/pixel_stream_processor_pkg.sv
// rtl/pixel_stream_processor_pkg.sv - shared encodings and luma constants for the pixel stream processor
package pixproc_pkg;

  typedef enum logic [2:0] {
    MODE_BYPASS = 3'd0,
    MODE_BRIGHT = 3'd1,
    MODE_INVERT = 3'd2,
    MODE_THRESH = 3'd3,
    MODE_SAT    = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_HBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  // Weights sum to 256, so luma never exceeds the component range.
  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/pixel_stream_processor_if.sv
// rtl/pixel_stream_processor_if.sv - pixel input stream and display-timing output bundle
interface pixel_stream_processor_if #(
  parameter int DATA_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              hsync;
  logic              vsync;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_data, hsync, vsync, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_data, hsync, vsync, done
  );
endinterface

// File: rtl/pixel_stream_processor_op_lane.sv
// rtl/pixel_stream_processor_op_lane.sv - two-stage point operator for one RGB pixel lane
module pixel_op_lane
  import pixproc_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic                         valid,
  input  logic [2:0]                   mode,
  input  logic signed [PIXEL_WIDTH:0]  bright_val,
  input  logic [PIXEL_WIDTH-1:0]       thresh_val,
  input  logic [2:0]                   sat_gain,
  input  logic [3*PIXEL_WIDTH-1:0]     pix_in,
  output logic [3*PIXEL_WIDTH-1:0]     pix_out
);

  localparam int PW     = PIXEL_WIDTH;
  localparam int SUM_W  = PW + 2;
  localparam int BR_W   = PW + 2;
  localparam int SAT_W  = PW + 5;
  localparam int LUMA_W = PW + 9;
  localparam logic [PW-1:0]           MAX   = {PW{1'b1}};
  localparam logic signed [SAT_W-1:0] MAX_S = SAT_W'((2 ** PW) - 1);

  logic [PW-1:0]           comp_in [3];
  logic [SUM_W-1:0]        sum_c;
  logic [PW-1:0]           y_c;
  logic signed [BR_W-1:0]  br_c [3];

  logic [PW-1:0]           c_q [3];
  logic [SUM_W-1:0]        sum_q;
  logic [PW-1:0]           y_q;
  logic signed [BR_W-1:0]  br_q [3];

  logic [PW-1:0]           avg;
  logic [PW-1:0]           inv_c;
  logic [PW-1:0]           thr_c;
  logic signed [SAT_W-1:0] sat_v [3];
  logic [PW-1:0]           res [3];

  function automatic logic [PW-1:0] clamp_pix(input logic signed [SAT_W-1:0] v);
    if (v < 0) return '0;
    if (v > MAX_S) return MAX;
    return v[PW-1:0];
  endfunction

  // Index 0 is R (most significant field), 2 is B.
  assign comp_in[0] = pix_in[3*PW-1 -: PW];
  assign comp_in[1] = pix_in[2*PW-1 -: PW];
  assign comp_in[2] = pix_in[PW-1 -: PW];

  always_comb begin
    sum_c = SUM_W'(comp_in[0]) + SUM_W'(comp_in[1]) + SUM_W'(comp_in[2]);
    y_c   = PW'((LUMA_W'(LUMA_R) * LUMA_W'(comp_in[0])
               + LUMA_W'(LUMA_G) * LUMA_W'(comp_in[1])
               + LUMA_W'(LUMA_B) * LUMA_W'(comp_in[2])) >> LUMA_SHIFT);
    for (int i = 0; i < 3; i++) begin
      br_c[i] = $signed({2'b00, comp_in[i]}) + $signed({bright_val[PW], bright_val});
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sum_q <= '0;
      y_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        c_q[i]  <= '0;
        br_q[i] <= '0;
      end
    end else if (load) begin
      sum_q <= sum_c;
      y_q   <= y_c;
      for (int i = 0; i < 3; i++) begin
        c_q[i]  <= comp_in[i];
        br_q[i] <= br_c[i];
      end
    end
  end

  always_comb begin
    avg   = PW'(sum_q / SUM_W'(3));
    inv_c = MAX - avg;
    thr_c = (avg > thresh_val) ? MAX : '0;
    for (int i = 0; i < 3; i++) begin
      sat_v[i] = $signed({{(SAT_W-PW){1'b0}}, y_q})
               + ($signed({{(SAT_W-PW){1'b0}}, c_q[i]}) - $signed({{(SAT_W-PW){1'b0}}, y_q}))
               * $signed({{(SAT_W-3){1'b0}}, sat_gain});
      res[i] = c_q[i];
      case (mode)
        MODE_BRIGHT: res[i] = clamp_pix({{(SAT_W-BR_W){br_q[i][BR_W-1]}}, br_q[i]});
        MODE_INVERT: res[i] = inv_c;
        MODE_THRESH: res[i] = thr_c;
        MODE_SAT:    res[i] = clamp_pix(sat_v[i]);
        default:     res[i] = c_q[i];
      endcase
    end
  end

  // Output is forced to zero on empty slots so the data bus is quiet outside hsync.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pix_out <= '0;
    end else begin
      pix_out <= valid ? {res[0], res[1], res[2]} : '0;
    end
  end

endmodule

// File: rtl/pixel_stream_processor.sv
// rtl/pixel_stream_processor.sv - frame sequencer, handshake and lane array for the pixel stream processor
module pixel_stream_processor
  import pixproc_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 384,
  parameter int IMAGE_HEIGHT = 256,
  parameter int LANES        = 2,
  parameter int PIXEL_WIDTH  = 8,
  parameter int VSYNC_LEN    = 100,
  parameter int HBLANK_LEN   = 160
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [2:0]                  mode,
  input  logic signed [PIXEL_WIDTH:0] bright_val,
  input  logic [PIXEL_WIDTH-1:0]      thresh_val,
  input  logic [2:0]                  sat_gain,
  pixel_stream_processor_if.slave     px,
  output logic                        underflow
);

  localparam int PIX_W   = 3 * PIXEL_WIDTH;
  localparam int COL_W   = $clog2(IMAGE_WIDTH) + 1;
  localparam int ROW_W   = $clog2(IMAGE_HEIGHT) + 1;
  localparam int TMR_LIM = (VSYNC_LEN > HBLANK_LEN) ? VSYNC_LEN : HBLANK_LEN;
  localparam int TMR_W   = $clog2(TMR_LIM) + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - LANES);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

  state_e                      state;
  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [TMR_W-1:0]            tmr;
  logic [2:0]                  cfg_mode;
  logic signed [PIXEL_WIDTH:0] cfg_bright;
  logic [PIXEL_WIDTH-1:0]      cfg_thresh;
  logic [2:0]                  cfg_gain;
  logic                        in_ready_q;
  logic                        vsync_q;
  logic                        done_q;
  logic                        underflow_q;
  logic                        s1_valid;
  logic                        s2_valid;
  logic                        accept;
  logic [LANES*PIX_W-1:0]      lane_out;

  assign accept = in_ready_q & px.in_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      tmr         <= '0;
      cfg_mode    <= '0;
      cfg_bright  <= '0;
      cfg_thresh  <= '0;
      cfg_gain    <= '0;
      in_ready_q  <= 1'b0;
      vsync_q     <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_VSYNC;
            vsync_q     <= 1'b1;
            tmr         <= '0;
            col         <= '0;
            row         <= '0;
            underflow_q <= 1'b0;
            cfg_mode    <= mode;
            cfg_bright  <= bright_val;
            cfg_thresh  <= thresh_val;
            cfg_gain    <= sat_gain;
          end
        end
        ST_VSYNC: begin
          if (tmr == TMR_W'(VSYNC_LEN - 1)) begin
            vsync_q <= 1'b0;
            tmr     <= '0;
            state   <= ST_HBLANK;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (tmr == TMR_W'(HBLANK_LEN - 1)) begin
            tmr        <= '0;
            in_ready_q <= 1'b1;
            state      <= ST_ACTIVE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (px.in_valid) begin
            if (col == LAST_COL) begin
              col        <= '0;
              in_ready_q <= 1'b0;
              if (row == LAST_ROW) begin
                row   <= '0;
                state <= ST_FLUSH;
              end else begin
                row   <= row + 1'b1;
                state <= ST_HBLANK;
              end
            end else begin
              col <= col + COL_W'(LANES);
            end
          end else begin
            underflow_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Stage 1 empty means the last beat leaves stage 2 on this edge.
          if (!s1_valid) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pixel_op_lane #(
      .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (accept),
      .valid      (s1_valid),
      .mode       (cfg_mode),
      .bright_val (cfg_bright),
      .thresh_val (cfg_thresh),
      .sat_gain   (cfg_gain),
      .pix_in     (px.in_data[PIX_W*k +: PIX_W]),
      .pix_out    (lane_out[PIX_W*k +: PIX_W])
    );
  end

  assign px.in_ready = in_ready_q;
  assign px.out_data = lane_out;
  assign px.hsync    = s2_valid;
  assign px.vsync    = vsync_q;
  assign px.done     = done_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_pixel_stream_processor.sv
// tb/tb_pixel_stream_processor.sv - randomized self-checking bench for pixel_stream_processor
module tb_pixel_stream_processor;

  localparam int LANES = 2;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int V     = 3;
  localparam int HB    = 2;
  localparam int PW    = 8;
  localparam int DW    = LANES * 3 * PW;
  localparam int BPR   = W / LANES;
  localparam int BEATS = BPR * H;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        mode = '0;
  logic signed [8:0] bright_val = '0;
  logic [7:0]        thresh_val = '0;
  logic [2:0]        sat_gain = '0;
  logic              underflow;

  pixel_stream_processor_if #(.DATA_W(DW)) px ();

  pixel_stream_processor #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .LANES       (LANES),
    .PIXEL_WIDTH (PW),
    .VSYNC_LEN   (V),
    .HBLANK_LEN  (HB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .bright_val (bright_val),
    .thresh_val (thresh_val),
    .sat_gain   (sat_gain),
    .px         (px),
    .underflow  (underflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [DW-1:0] exp_out [int];
  int start_cyc = -1000, exp_rise = -1, done_exp = -1, done_cyc = -1;
  int beats = 0, done_cnt = 0;
  logic uf_model = 1'b0, prev_rdy = 1'b0, busy = 1'b0, rst_prev = 1'b0;
  logic [DW-1:0] last_out = '0;
  int f_mode = 0, f_bv = 0, f_tv = 0, f_g = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [23:0] model_pix(input logic [23:0] p);
    int c [3];
    int o [3];
    int avg, y;
    c[0] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[2] = int'(p[7:0]);
    avg = (c[0] + c[1] + c[2]) / 3;
    y   = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
    for (int i = 0; i < 3; i++) begin
      case (f_mode)
        1:       o[i] = sat255(c[i] + f_bv);
        2:       o[i] = 255 - avg;
        3:       o[i] = (avg > f_tv) ? 255 : 0;
        4:       o[i] = sat255(y + (c[i] - y) * f_g);
        default: o[i] = c[i];
      endcase
    end
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[24*k +: 24] = model_pix(d[24*k +: 24]);
    return r;
  endfunction

  always @(negedge clock) begin
    logic [DW-1:0] e;
    logic ev;
    ev = exp_out.exists(cyc);
    e  = ev ? exp_out[cyc] : '0;
    check("hsync", 64'(px.hsync), 64'(ev));
    check("out_data", 64'(px.out_data), 64'(e));
    if (ev) begin
      last_out = px.out_data;
      exp_out.delete(cyc);
    end
    check("vsync", 64'(px.vsync), 64'(cyc > start_cyc && cyc <= start_cyc + V));
    check("done", 64'(px.done), 64'(cyc == done_exp));
    check("underflow", 64'(underflow), 64'(uf_model));
    if (rst_prev) check("ready_after_reset", 64'(px.in_ready), 64'(0));
    if (px.in_ready && !prev_rdy) check("ready_rise_cycle", 64'(cyc), 64'(exp_rise));
    if (px.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_rdy = px.in_ready;
    if (cyc == done_exp) busy = 1'b0;
    if (!reset_n) begin
      exp_out.delete();
      start_cyc = -1000;
      exp_rise  = -1;
      done_exp  = -1;
      uf_model  = 1'b0;
      prev_rdy  = 1'b0;
      busy      = 1'b0;
    end else begin
      if (start && !busy) begin
        busy      = 1'b1;
        uf_model  = 1'b0;
        start_cyc = cyc;
        exp_rise  = cyc + V + HB + 1;
        beats     = 0;
      end
      if (px.in_ready && px.in_valid) begin
        exp_out[cyc + 2] = model_beat(px.in_data);
        beats++;
        if (beats % BPR == 0 && beats < BEATS) exp_rise = cyc + HB + 1;
        if (beats == BEATS) done_exp = cyc + 3;
      end else if (px.in_ready) begin
        uf_model = 1'b1;
      end
    end
    rst_prev = !reset_n;
  end

  task automatic run_frame(input int md, input int bv, input int tv, input int g, input int vpct,
                           input bit fixed, input logic [23:0] pix, input int stall_at,
                           input int stall_len, input int rst_at);
    int t, sl, d0;
    f_mode = md; f_bv = bv; f_tv = tv; f_g = g;
    mode = 3'(md); bright_val = 9'(bv); thresh_val = 8'(tv); sat_gain = 3'(g);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    sl = stall_len;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      mode = 3'($urandom); bright_val = 9'($urandom); thresh_val = 8'($urandom); sat_gain = 3'($urandom);
      px.in_data = fixed ? {LANES{pix}} : DW'({$urandom(), $urandom()});
      start = px.in_ready && ($urandom_range(9) == 0);
      if (px.in_ready && beats == stall_at && sl > 0) begin
        px.in_valid = 1'b0;
        sl--;
      end else begin
        px.in_valid = ($urandom_range(99) < vpct);
      end
      if (rst_at >= 0 && beats == rst_at && px.in_ready) begin
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        px.in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        return;
      end
      @(posedge clock); #1;
      t++;
    end
    start = 1'b0;
    px.in_valid = 1'b0;
    check("frame_done_count", 64'(done_cnt - d0), 64'(1));
    repeat (2) @(posedge clock);
    #1;
  endtask

  int            d_mode [7] = '{1, 1, 3, 3, 2, 4, 4};
  int            d_bv   [7] = '{100, -100, 0, 0, 0, 0, 0};
  int            d_tv   [7] = '{0, 0, 90, 90, 0, 0, 0};
  int            d_g    [7] = '{0, 0, 0, 0, 0, 2, 0};
  logic [23:0]   d_pix  [7] = '{24'hC80A9B, 24'h3264FF, 24'h5B5B5B, 24'h5A5A5C,
                               24'h1E3C5A, 24'hC86432, 24'hC86432};
  logic [23:0]   d_lit  [7] = '{24'hFF6EFF, 24'h00009B, 24'hFFFFFF, 24'h000000,
                               24'hC3C3C3, 24'hFF4C00, 24'h7C7C7C};

  initial begin
    px.in_valid = 1'b0;
    px.in_data  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_frame(0, 0, 0, 0, 100, 1'b0, 24'h0, -1, 0, -1);
    check("bypass_frame_len", 64'(done_cyc - start_cyc), 64'(14));
    check("bypass_no_underflow", 64'(underflow), 64'(0));

    for (int i = 0; i < 7; i++) begin
      run_frame(d_mode[i], d_bv[i], d_tv[i], d_g[i], 100, 1'b1, d_pix[i], -1, 0, -1);
      check($sformatf("literal_pixel_%0d", i), 64'(last_out[23:0]), 64'(d_lit[i]));
    end

    run_frame(int'($urandom_range(7)), int'($urandom_range(511)) - 256, int'($urandom_range(255)),
              int'($urandom_range(7)), 100, 1'b0, 24'h0, 1, 5, -1);
    check("stall_frame_len", 64'(done_cyc - start_cyc), 64'(19));
    check("stall_underflow", 64'(underflow), 64'(1));

    run_frame(4, 0, 0, 3, 100, 1'b0, 24'h0, -1, 0, 1);
    run_frame(0, 0, 0, 0, 100, 1'b0, 24'h0, -1, 0, -1);
    check("post_reset_frame_len", 64'(done_cyc - start_cyc), 64'(14));

    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(7)), int'($urandom_range(511)) - 256, int'($urandom_range(255)),
                int'($urandom_range(7)), 70, 1'b0, 24'h0, -1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
